// File: rtl/aib_sl_calib_fsm.sv
// Follower-side AIB calibration sequencer: waits for leader POR/config, wakes the
// channels, requests DCC/DLL lock and supervises link-up with bounded retries.
module aib_sl_calib_fsm #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int WAIT_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_por_released,
  input  logic                      m_conf_done,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  input  logic                      retrain_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] sl_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
  output logic                      sl_conf_done,
  output logic                      link_ready,
  output logic                      link_error,
  output logic [3:0]                attempt_cnt,
  output logic [2:0]                state_o
);

  // state       | meaning
  // IDLE        | all outputs low, restart sequence
  // WAIT_POR    | wait for leader POR plus settle delay
  // CONFIG      | follower config done, wait for leader config
  // WAKEUP      | MAC ready / adapter out of reset, settle delay
  // WAIT_LINKUP | DCC/DLL lock requested, wait for all transfer enables
  // LINKED      | link up, watch for loss or retrain
  // ERROR       | retries exhausted, wait for retrain or reset
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_POR    = 3'd1,
    CONFIG      = 3'd2,
    WAKEUP      = 3'd3,
    WAIT_LINKUP = 3'd4,
    LINKED      = 3'd5,
    ERROR       = 3'd6
  } state_t;

  localparam logic [15:0] WAIT_LAST    = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  logic   por_q1, por_s;
  logic   conf_q1, conf_s;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [3:0]  nxt_attempt;
  logic [3:0]  attempt_inc;
  logic        link_up;
  logic        cnt_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      por_q1  <= 1'b0;
      por_s   <= 1'b0;
      conf_q1 <= 1'b0;
      conf_s  <= 1'b0;
    end else begin
      por_q1  <= m_por_released;
      por_s   <= por_q1;
      conf_q1 <= m_conf_done;
      conf_s  <= conf_q1;
    end
  end

  assign link_up     = (&sl_tx_transfer_en) & (&sl_rx_transfer_en);
  assign attempt_inc = attempt_cnt + 4'd1;

  // Loss of leader POR overrides everything except in IDLE/WAIT_POR/ERROR.
  always_comb begin
    nxt         = state;
    nxt_attempt = attempt_cnt;
    case (state)
      IDLE: nxt = WAIT_POR;
      WAIT_POR: begin
        if (por_s && cnt == WAIT_LAST) nxt = CONFIG;
      end
      CONFIG: begin
        if (!por_s)      nxt = IDLE;
        else if (conf_s) nxt = WAKEUP;
      end
      WAKEUP: begin
        if (!por_s)                nxt = IDLE;
        else if (cnt == WAIT_LAST) nxt = WAIT_LINKUP;
      end
      WAIT_LINKUP: begin
        if (!por_s)       nxt = IDLE;
        else if (link_up) nxt = LINKED;
        else if (cnt == TIMEOUT_LAST) begin
          nxt_attempt = attempt_inc;
          nxt         = (attempt_inc == RETRY_LIMIT) ? ERROR : WAKEUP;
        end
      end
      LINKED: begin
        if (!por_s) nxt = IDLE;
        else if (!link_up || retrain_req) begin
          nxt         = WAKEUP;
          nxt_attempt = 4'd0;
        end
      end
      ERROR: begin
        if (retrain_req) begin
          nxt         = IDLE;
          nxt_attempt = 4'd0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign cnt_clr = (nxt != state) || (state == WAIT_POR && !por_s);

  // Outputs are registered from the next state so they stay aligned with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      cnt                    <= 16'd0;
      attempt_cnt            <= 4'd0;
      sl_conf_done           <= 1'b0;
      sl_mac_rdy             <= '0;
      sl_adapter_rstn        <= '0;
      sl_rx_dcc_dll_lock_req <= '0;
      sl_tx_dcc_dll_lock_req <= '0;
      link_ready             <= 1'b0;
      link_error             <= 1'b0;
    end else begin
      state       <= nxt;
      attempt_cnt <= nxt_attempt;
      if (cnt_clr)              cnt <= 16'd0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;

      sl_conf_done           <= 1'b0;
      sl_mac_rdy             <= '0;
      sl_adapter_rstn        <= '0;
      sl_rx_dcc_dll_lock_req <= '0;
      sl_tx_dcc_dll_lock_req <= '0;
      link_ready             <= 1'b0;
      link_error             <= 1'b0;
      case (nxt)
        CONFIG: sl_conf_done <= 1'b1;
        WAKEUP: begin
          sl_conf_done    <= 1'b1;
          sl_mac_rdy      <= '1;
          sl_adapter_rstn <= '1;
        end
        WAIT_LINKUP, LINKED: begin
          sl_conf_done           <= 1'b1;
          sl_mac_rdy             <= '1;
          sl_adapter_rstn        <= '1;
          sl_rx_dcc_dll_lock_req <= '1;
          sl_tx_dcc_dll_lock_req <= '1;
          link_ready             <= (nxt == LINKED);
        end
        ERROR:   link_error <= 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_aib_sl_calib_fsm.sv
// Scoreboard bench: every expected state entry (with its full output vector) is
// queued by the stimulus; the monitor pops and compares on each state change.
module tb_aib_sl_calib_fsm;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m_por_released = 1'b0;
  logic         m_conf_done = 1'b0;
  logic [N-1:0] sl_tx_transfer_en = '0;
  logic [N-1:0] sl_rx_transfer_en = '0;
  logic         retrain_req = 1'b0;
  logic [N-1:0] sl_mac_rdy, sl_adapter_rstn, sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req;
  logic         sl_conf_done, link_ready, link_error;
  logic [3:0]   attempt_cnt;
  logic [2:0]   state_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] sb[$];

  aib_sl_calib_fsm #(
    .TOTAL_CHNL_NUM(N), .WAIT_CYCLES(8), .TIMEOUT_CYCLES(32), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .m_por_released(m_por_released), .m_conf_done(m_conf_done),
    .sl_tx_transfer_en(sl_tx_transfer_en), .sl_rx_transfer_en(sl_rx_transfer_en),
    .retrain_req(retrain_req),
    .sl_mac_rdy(sl_mac_rdy), .sl_adapter_rstn(sl_adapter_rstn),
    .sl_rx_dcc_dll_lock_req(sl_rx_dcc_dll_lock_req),
    .sl_tx_dcc_dll_lock_req(sl_tx_dcc_dll_lock_req),
    .sl_conf_done(sl_conf_done), .link_ready(link_ready), .link_error(link_error),
    .attempt_cnt(attempt_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {state, conf_done, mac_rdy, adapter_rstn, rx_dll, tx_dll, link_ready, link_error, attempt}
  function automatic logic [25:0] exp_vec(input logic [2:0] st, input logic [3:0] att);
    logic conf, lr, le;
    logic [3:0] mac, dll;
    conf = 1'b0; lr = 1'b0; le = 1'b0; mac = 4'h0; dll = 4'h0;
    case (st)
      3'd2: conf = 1'b1;
      3'd3: begin conf = 1'b1; mac = 4'hF; end
      3'd4: begin conf = 1'b1; mac = 4'hF; dll = 4'hF; end
      3'd5: begin conf = 1'b1; mac = 4'hF; dll = 4'hF; lr = 1'b1; end
      3'd6: le = 1'b1;
      default: ;
    endcase
    return {st, conf, mac, mac, dll, dll, lr, le, att};
  endfunction

  function automatic logic [25:0] act_vec();
    return {state_o, sl_conf_done, sl_mac_rdy, sl_adapter_rstn, sl_rx_dcc_dll_lock_req,
            sl_tx_dcc_dll_lock_req, link_ready, link_error, attempt_cnt};
  endfunction

  task automatic expect_st(input logic [2:0] st, input logic [3:0] att);
    sb.push_back(exp_vec(st, att));
  endtask

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s: %0d expected states still pending after %0d cycles", name, sb.size(), budget);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state_o == s) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s: state %0d not reached, got %0d", name, s, state_o);
  endtask

  // Monitor: each observed state change must match the head of the scoreboard.
  initial begin
    logic [2:0] prev;
    logic [25:0] exp;
    prev = 3'd0;
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (state_o !== prev) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_state: got %h want none (state %0d -> %0d)", act_vec(), prev, state_o);
        end else begin
          exp = sb.pop_front();
          check($sformatf("state_entry_%0d", state_o), act_vec(), exp);
        end
        prev = state_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_state", act_vec(), exp_vec(3'd0, 4'd0));
    expect_st(3'd1, 4'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Nominal bring-up 1,2,3,4,5
    expect_st(3'd2, 4'd0); expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd5, 4'd0);
    m_por_released = 1'b1; m_conf_done = 1'b1;
    sl_tx_transfer_en = 4'hF; sl_rx_transfer_en = 4'hF;
    wait_drain(200, "nominal");

    // TX lane 3 dead: link lost, one timeout retry, then lane recovers
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd3, 4'd1); expect_st(3'd4, 4'd1);
    sl_tx_transfer_en = 4'h7;
    wait_drain(200, "retry_once");
    expect_st(3'd5, 4'd1);
    sl_tx_transfer_en = 4'hF;
    wait_drain(50, "relink_att1");

    // One-cycle RX[2] drop: back to WAKEUP with attempt cleared
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd5, 4'd0);
    sl_rx_transfer_en = 4'hB;
    @(negedge clk);
    sl_rx_transfer_en = 4'hF;
    wait_drain(100, "link_loss");

    // Link completes in exactly the timeout cycle
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0);
    sl_tx_transfer_en = 4'h7;
    wait_state(3'd4, 100, "boundary_enter");
    expect_st(3'd5, 4'd0);
    repeat (31) @(negedge clk);
    sl_tx_transfer_en = 4'hF;
    wait_drain(20, "boundary_link");

    // Retrain request while linked
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd5, 4'd0);
    retrain_req = 1'b1;
    @(negedge clk);
    retrain_req = 1'b0;
    wait_drain(100, "retrain_linked");

    // Retries exhausted -> ERROR, held until retrain
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd3, 4'd1);
    expect_st(3'd4, 4'd1); expect_st(3'd6, 4'd2);
    sl_tx_transfer_en = 4'h7;
    wait_drain(300, "to_error");
    repeat (40) @(negedge clk);
    sl_tx_transfer_en = 4'hF;
    expect_st(3'd0, 4'd0); expect_st(3'd1, 4'd0); expect_st(3'd2, 4'd0);
    expect_st(3'd3, 4'd0); expect_st(3'd4, 4'd0); expect_st(3'd5, 4'd0);
    retrain_req = 1'b1;
    @(negedge clk);
    retrain_req = 1'b0;
    wait_drain(200, "error_retrain");

    // Leader POR drop while linked: IDLE after the synchronizer latency
    expect_st(3'd0, 4'd0); expect_st(3'd1, 4'd0);
    m_por_released = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (state_o == 3'd0) begin cyc = i; break; end
    end
    n_cmp++;
    if (cyc == 0 || cyc > 3) begin
      n_bad++;
      $display("FAIL por_drop_latency: got %0d cycles want 1..3", cyc);
    end
    wait_drain(20, "por_drop");

    // Asynchronous reset in the middle of WAKEUP
    expect_st(3'd2, 4'd0); expect_st(3'd3, 4'd0);
    m_por_released = 1'b1;
    wait_state(3'd3, 100, "wakeup_for_reset");
    #3;
    expect_st(3'd0, 4'd0);
    rst = 1'b1;
    #1;
    check("async_reset", act_vec(), exp_vec(3'd0, 4'd0));
    m_por_released = 1'b0; m_conf_done = 1'b0;
    repeat (3) @(negedge clk);
    expect_st(3'd1, 4'd0);
    rst = 1'b0;
    wait_drain(20, "reset_release");
    repeat (5) @(negedge clk);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aib_sl_calib_fsm.md
AIB_SL_CALIB_FSM -- requirements
Module: aib_sl_calib_fsm

Interface
REQ-001 SHALL have parameter TOTAL_CHNL_NUM, default 24, meaning number of AIB channels.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1000, meaning the settle delay in clk cycles, range 1..65535.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the link-up timeout in clk cycles, range 1..65535.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning the number of link-up attempts before error, range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port m_por_released, input, 1 bit: the leader die has released power-on reset (asynchronous to clk).
REQ-008 SHALL have port m_conf_done, input, 1 bit: the leader configuration is complete (asynchronous to clk).
REQ-009 SHALL have port sl_tx_transfer_en, input, TOTAL_CHNL_NUM bits: per-channel follower TX transfer enable.
REQ-010 SHALL have port sl_rx_transfer_en, input, TOTAL_CHNL_NUM bits: per-channel follower RX transfer enable.
REQ-011 SHALL have port retrain_req, input, 1 bit: a single-cycle request to recalibrate.
REQ-012 SHALL have ports sl_mac_rdy, sl_adapter_rstn, sl_rx_dcc_dll_lock_req and sl_tx_dcc_dll_lock_req, each output, TOTAL_CHNL_NUM bits: the follower channel controls.
REQ-013 SHALL have port sl_conf_done, output, 1 bit: the follower configuration is complete.
REQ-014 SHALL have ports link_ready and link_error, each output, 1 bit: link-up status and terminal failure.
REQ-015 SHALL have port attempt_cnt, output, 4 bits: the link-up attempts consumed.
REQ-016 SHALL have port state_o, output, 3 bits: the current state encoding.

Function
REQ-017 SHALL pass m_por_released and m_conf_done through 2-flop synchronizers (por_s, conf_s), giving 2 cycles of input latency.
REQ-018 SHALL encode the states as IDLE=0, WAIT_POR=1, CONFIG=2, WAKEUP=3, WAIT_LINKUP=4, LINKED=5, ERROR=6.
REQ-019 SHALL clear a 16-bit delay counter on every state change and increment it each cycle otherwise, saturating at 16'hFFFF.
REQ-020 SHALL decode outputs from the state register only (Moore), with no combinational path from any input.
REQ-021 SHALL in IDLE drive all outputs 0 and move to WAIT_POR on the next cycle.
REQ-022 SHALL in WAIT_POR clear the counter while por_s=0, and move to CONFIG when the counter reaches WAIT_CYCLES-1 with por_s=1.
REQ-023 SHALL in CONFIG drive sl_conf_done=1 and move to WAKEUP when conf_s=1.
REQ-024 SHALL in WAKEUP drive sl_conf_done=1 and sl_mac_rdy and sl_adapter_rstn all-ones, and move to WAIT_LINKUP when the counter reaches WAIT_CYCLES-1.
REQ-025 SHALL in WAIT_LINKUP additionally drive both dll_lock_req buses all-ones.
REQ-026 SHALL move from WAIT_LINKUP to LINKED when sl_tx_transfer_en and sl_rx_transfer_en are both all-ones.
REQ-027 SHALL on a WAIT_LINKUP timeout (counter reaches TIMEOUT_CYCLES-1 without link) increment attempt_cnt, then move to ERROR if the new value equals MAX_RETRY, else to WAKEUP.
REQ-028 SHALL in LINKED drive the WAIT_LINKUP outputs plus link_ready=1.
REQ-029 SHALL leave LINKED for WAKEUP when any transfer_en bit drops or retrain_req=1, and clear attempt_cnt on that transition.
REQ-030 SHALL in ERROR drive link_error=1 with all channel buses 0, holding until reset or until retrain_req=1 moves it to IDLE with attempt_cnt cleared.
REQ-031 SHALL from CONFIG, WAKEUP, WAIT_LINKUP or LINKED move to IDLE when por_s=0, with priority over every other transition; attempt_cnt is kept.
REQ-032 SHALL give link-up priority over timeout when both occur in the same cycle.
REQ-033 SHALL ignore retrain_req in IDLE, WAIT_POR, CONFIG, WAKEUP and WAIT_LINKUP.

Reset
REQ-034 SHALL while rst=1, at any time including mid-calibration, force state IDLE, counter 0 and attempt_cnt 0, with all outputs 0 within the same cycle.
REQ-035 SHALL clear the synchronizer flops to 0 on reset.
REQ-036 SHALL enter WAIT_POR on the first rising clk edge after rst deasserts.

Verification (N=4, WAIT_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRY=2)
REQ-037 SHALL check nominal bring-up: por=1, conf=1, transfer_en both 4'hF at WAIT_LINKUP entry -> state_o sequence 1,2,3,4,5; link_ready=1; sl_mac_rdy=4'hF.
REQ-038 SHALL check timeout and retry: transfer_en held 4'h7 -> WAKEUP re-entered with attempt_cnt=1, then ERROR with attempt_cnt=2 and link_error=1 and buses 0; retrain_req -> IDLE with attempt_cnt=0.
REQ-039 SHALL check link loss: in LINKED, sl_rx_transfer_en[2]=0 for 1 cycle -> WAKEUP, link_ready=0, dll_lock_req=0, attempt_cnt=0.
REQ-040 SHALL check leader POR drop: m_por_released=0 while in LINKED -> IDLE within 3 cycles and all outputs 0.
REQ-041 SHALL check the simultaneous boundary: transfer_en reaches 4'hF in the same cycle as timeout -> LINKED, attempt_cnt unchanged.
REQ-042 SHALL check asynchronous reset: rst pulsed mid-WAKEUP, not clock-aligned -> outputs 0 immediately and state_o=0.
